usb_slave_fifo_writer: RTL and testbench

Downstream stage of the two-channel FIFO merger. It accepts the merged 16-bit word stream (`din`/`din_en`) and drives a Cypress FX2-style synchronous slave-FIFO write port, where IFCLK equals `clk`. A small elastic buffer absorbs host back-pressure. An idle timer commits short packets with PKTEND, and a sticky flag reports any words lost to overflow.

---
 rtl/usb_slave_fifo_writer.sv | 175 +++++++++++++++++
 tb/tb_usb_slave_fifo_writer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_slave_fifo_writer.sv
// FX2-style synchronous slave-FIFO writer: elastic buffer in front of the host FIFO,
// idle-timeout PKTEND for short packets, sticky overflow flag and a sent-word counter.
module usb_slave_fifo_writer #(
  parameter int unsigned BUF_AW       = 4,
  parameter int unsigned PKT_WORDS    = 256,
  parameter int unsigned IDLE_TIMEOUT = 1024,
  parameter logic [1:0]  EP_ADDR      = 2'b10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rst_all_fifo,
  input  logic [15:0] din,
  input  logic        din_en,
  input  logic        usb_pfull_n,
  output logic [15:0] usb_fd,
  output logic        usb_slwr_n,
  output logic        usb_pktend_n,
  output logic [1:0]  usb_fifoadr,
  output logic        overflow,
  output logic [15:0] words_sent
);

  localparam int unsigned Depth = 2 ** BUF_AW;
  localparam int unsigned PktW  = $clog2(PKT_WORDS);
  localparam int unsigned IdleW = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [BUF_AW:0]  DepthCnt = (BUF_AW + 1)'(Depth);
  localparam logic [PktW-1:0]  PktLast  = PktW'(PKT_WORDS - 1);
  localparam logic [IdleW-1:0] IdleMax  = IdleW'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {StIdle, StStream, StPktend} state_e;

  state_e            state_q, state_d;
  logic [BUF_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [BUF_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [BUF_AW:0]   count_q, count_d;
  logic [PktW-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic [IdleW-1:0]  idle_q, idle_d;
  logic [15:0]       fd_q, fd_d;
  logic              slwr_n_q, slwr_n_d;
  logic              pktend_n_q, pktend_n_d;
  logic              ovf_q, ovf_d;
  logic [15:0]       ws_q, ws_d;

  logic [15:0] mem [Depth];

  logic buf_empty, buf_full;
  logic launch, push, drop;

  assign buf_empty = (count_q == '0);
  assign buf_full  = (count_q == DepthCnt);

  // A pop frees the slot in the same cycle, so a full buffer still accepts a word on launch.
  assign launch = !buf_empty && usb_pfull_n && (state_q != StPktend) && !rst_all_fifo;
  assign push   = din_en && (!buf_full || launch) && !rst_all_fifo;
  assign drop   = din_en && buf_full && !launch && !rst_all_fifo;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= din;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    pkt_cnt_d  = pkt_cnt_q;
    idle_d     = idle_q;
    fd_d       = fd_q;
    slwr_n_d   = 1'b1;
    pktend_n_d = 1'b1;
    ovf_d      = ovf_q | drop;
    ws_d       = ws_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    if (launch) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      fd_d      = mem[rd_ptr_q];
      slwr_n_d  = 1'b0;
      ws_d      = ws_q + 16'd1;
      // Full packets are committed by the host, so the count just wraps.
      pkt_cnt_d = (pkt_cnt_q == PktLast) ? '0 : pkt_cnt_q + 1'b1;
    end

    case ({push, launch})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (push || launch) begin
      idle_d = '0;
    end else if ((state_q == StStream) && buf_empty && (pkt_cnt_q != '0)) begin
      idle_d = idle_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if ((count_d != '0) || (pkt_cnt_d != '0)) begin
          state_d = StStream;
        end
      end
      StStream: begin
        if (idle_q == IdleMax) begin
          state_d    = StPktend;
          pktend_n_d = 1'b0;
          idle_d     = '0;
        end else if ((count_d == '0) && (pkt_cnt_d == '0)) begin
          state_d = StIdle;
        end
      end
      StPktend: begin
        state_d   = StIdle;
        pkt_cnt_d = '0;
        idle_d    = '0;
      end
      default: state_d = StIdle;
    endcase

    if (rst_all_fifo) begin
      state_d    = StIdle;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      pkt_cnt_d  = '0;
      idle_d     = '0;
      fd_d       = '0;
      slwr_n_d   = 1'b1;
      pktend_n_d = 1'b1;
      ovf_d      = 1'b0;
      ws_d       = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pkt_cnt_q  <= '0;
      idle_q     <= '0;
      fd_q       <= '0;
      slwr_n_q   <= 1'b1;
      pktend_n_q <= 1'b1;
      ovf_q      <= 1'b0;
      ws_q       <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pkt_cnt_q  <= pkt_cnt_d;
      idle_q     <= idle_d;
      fd_q       <= fd_d;
      slwr_n_q   <= slwr_n_d;
      pktend_n_q <= pktend_n_d;
      ovf_q      <= ovf_d;
      ws_q       <= ws_d;
    end
  end

  assign usb_fd       = fd_q;
  assign usb_slwr_n   = slwr_n_q;
  assign usb_pktend_n = pktend_n_q;
  assign usb_fifoadr  = EP_ADDR;
  assign overflow     = ovf_q;
  assign words_sent   = ws_q;

endmodule

// File: tb/tb_usb_slave_fifo_writer.sv
// Bench for usb_slave_fifo_writer: scenario table, hand-written corner sequences and a
// randomized run, all compared against a queue-based reference model every cycle.
module tb_usb_slave_fifo_writer;

  localparam int Timeout  = 1024;
  localparam int PktWords = 256;
  localparam int Depth    = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rst_all_fifo = 1'b0;
  logic [15:0] din = '0;
  logic        din_en = 1'b0;
  logic        usb_pfull_n = 1'b1;
  logic [15:0] usb_fd;
  logic        usb_slwr_n;
  logic        usb_pktend_n;
  logic [1:0]  usb_fifoadr;
  logic        overflow;
  logic [15:0] words_sent;

  usb_slave_fifo_writer #(
    .BUF_AW      (4),
    .PKT_WORDS   (PktWords),
    .IDLE_TIMEOUT(Timeout),
    .EP_ADDR     (2'b10)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rst_all_fifo(rst_all_fifo),
    .din         (din),
    .din_en      (din_en),
    .usb_pfull_n (usb_pfull_n),
    .usb_fd      (usb_fd),
    .usb_slwr_n  (usb_slwr_n),
    .usb_pktend_n(usb_pktend_n),
    .usb_fifoadr (usb_fifoadr),
    .overflow    (overflow),
    .words_sent  (words_sent)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: host-visible behaviour from the word-level rules.
  logic [15:0] m_q[$];
  logic [15:0] m_fd = '0;
  logic        m_slwr_n = 1'b1;
  logic        m_pktend_n = 1'b1;
  logic        m_ovf = 1'b0;
  logic        m_pkt = 1'b0;
  logic [15:0] m_ws = '0;
  int          m_pkt_cnt = 0;
  int          m_idle = 0;

  task automatic model_clear();
    m_q.delete();
    m_fd = '0;
    m_slwr_n = 1'b1;
    m_pktend_n = 1'b1;
    m_ovf = 1'b0;
    m_pkt = 1'b0;
    m_ws = '0;
    m_pkt_cnt = 0;
    m_idle = 0;
  endtask

  always @(posedge clk or negedge reset_n) begin : model_blk
    int n;
    bit launch, push, drop;
    if (!reset_n || rst_all_fifo) begin
      model_clear();
    end else begin
      n = m_q.size();
      launch = (n != 0) && usb_pfull_n && !m_pkt;
      push = din_en && ((n < Depth) || launch);
      drop = din_en && !push;
      if (m_pkt) begin
        m_pktend_n = 1'b1;
        m_slwr_n = 1'b1;
        m_pkt_cnt = 0;
        m_idle = 0;
        m_pkt = 1'b0;
      end else if (m_idle == Timeout) begin
        m_pkt = 1'b1;
        m_pktend_n = 1'b0;
        m_slwr_n = 1'b1;
        m_idle = 0;
      end else begin
        m_pktend_n = 1'b1;
        if (launch) begin
          m_fd = m_q.pop_front();
          m_slwr_n = 1'b0;
          m_ws = m_ws + 16'd1;
          m_pkt_cnt = (m_pkt_cnt + 1) % PktWords;
          m_idle = 0;
        end else begin
          m_slwr_n = 1'b1;
          if (push) m_idle = 0;
          else if ((n == 0) && (m_pkt_cnt != 0)) m_idle = m_idle + 1;
        end
      end
      if (push) m_q.push_back(din);
      if (drop) m_ovf = 1'b1;
    end
  end

  // Per-cycle comparison and strobe monitor.
  logic [15:0] got_q[$];
  int pkt_seen = 0;
  int first_strobe = -1;
  int last_strobe = -1;
  int pkt_cyc = -1;

  always @(negedge clk) begin
    if (chk_on) begin
      check("model", {27'b0, usb_fifoadr, usb_fd, usb_slwr_n, usb_pktend_n, overflow, words_sent},
            {27'b0, 2'b10, m_fd, m_slwr_n, m_pktend_n, m_ovf, m_ws});
      check("strobe_excl", 64'(usb_slwr_n | usb_pktend_n), 64'd1);
      if (!usb_slwr_n) begin
        got_q.push_back(usb_fd);
        if (first_strobe < 0) first_strobe = cyc;
        last_strobe = cyc;
      end
      if (!usb_pktend_n) begin
        pkt_seen++;
        pkt_cyc = cyc;
      end
    end
  end

  task automatic mon_reset();
    got_q.delete();
    pkt_seen = 0;
    first_strobe = -1;
    last_strobe = -1;
    pkt_cyc = -1;
  endtask

  task automatic drive(input logic en, input logic [15:0] d, input logic pf);
    @(negedge clk);
    din_en = en;
    din = d;
    usb_pfull_n = pf;
  endtask

  task automatic do_clear();
    @(negedge clk);
    rst_all_fifo = 1'b1;
    din_en = 1'b1;
    din = 16'hdead;
    usb_pfull_n = 1'b1;
    @(negedge clk);
    rst_all_fifo = 1'b0;
    din_en = 1'b0;
    mon_reset();
  endtask

  typedef struct {
    bit clear;
    int base;
    int n;
    int stall_at;
    int stall_len;
    int idle;
    int exp_strobes;
    int exp_ws;
    bit exp_ovf;
    int exp_pkt;
    int exp_gap;
    bit chk_lat;
  } vec_t;

  vec_t tbl[6];

  task automatic run_entry(input int idx, input vec_t v);
    int total, sample_cyc;
    bit ok;
    bit stalled;
    if (v.clear) do_clear();
    else mon_reset();
    total = v.n;
    if (v.stall_len > 0 && v.stall_at + v.stall_len > total) total = v.stall_at + v.stall_len;
    sample_cyc = -1;
    for (int t = 0; t < total; t++) begin
      stalled = (v.stall_len > 0) && (t >= v.stall_at) && (t < v.stall_at + v.stall_len);
      drive(t < v.n, 16'(v.base + t), !stalled);
      if (t == 0) sample_cyc = cyc + 1;
    end
    for (int t = 0; t < v.idle; t++) drive(1'b0, 16'h0, 1'b1);
    check($sformatf("v%0d_strobes", idx), 64'(got_q.size()), 64'(v.exp_strobes));
    ok = 1'b1;
    for (int i = 0; i < got_q.size(); i++) begin
      if (got_q[i] !== 16'(v.base + i)) ok = 1'b0;
    end
    check($sformatf("v%0d_order", idx), 64'(ok), 64'd1);
    check($sformatf("v%0d_words_sent", idx), 64'(words_sent), 64'(v.exp_ws));
    check($sformatf("v%0d_overflow", idx), 64'(overflow), 64'(v.exp_ovf));
    check($sformatf("v%0d_pktend", idx), 64'(pkt_seen), 64'(v.exp_pkt));
    if (v.exp_gap != 0) check($sformatf("v%0d_gap", idx), 64'(pkt_cyc - last_strobe), 64'(v.exp_gap));
    if (v.chk_lat) check($sformatf("v%0d_latency", idx), 64'(first_strobe - sample_cyc), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited, stall_left, gap_left;
    bit found;

    //        clr   base  n    st_at st_len idle  strb  ws   ovf   pkt gap   lat
    tbl[0] = '{1'b1, 0,    600, 0,    0,     20,   600,  600, 1'b0, 0,  0,    1'b1};
    tbl[1] = '{1'b1, 100,  10,  0,    0,     1100, 10,   10,  1'b0, 1,  1025, 1'b1};
    tbl[2] = '{1'b0, 1000, 256, 0,    0,     1100, 256,  266, 1'b0, 0,  0,    1'b0};
    tbl[3] = '{1'b1, 2000, 40,  10,   12,    30,   40,   40,  1'b0, 0,  0,    1'b0};
    tbl[4] = '{1'b1, 3000, 20,  0,    24,    40,   16,   16,  1'b1, 0,  0,    1'b0};
    tbl[5] = '{1'b1, 4000, 5,   0,    0,     10,   5,    5,   1'b0, 0,  0,    1'b0};

    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_fd", 64'(usb_fd), 64'd0);
    check("rst_slwr_n", 64'(usb_slwr_n), 64'd1);
    check("rst_pktend_n", 64'(usb_pktend_n), 64'd1);
    check("rst_fifoadr", 64'(usb_fifoadr), 64'd2);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_words_sent", 64'(words_sent), 64'd0);
    chk_on = 1'b1;

    for (int i = 0; i < 6; i++) run_entry(i, tbl[i]);

    // Push during the PKTEND cycle.
    do_clear();
    for (int i = 0; i < 3; i++) drive(1'b1, 16'(16'h0700 + i), 1'b1);
    found = 1'b0;
    for (waited = 0; waited < 1200 && !found; waited++) begin
      drive(1'b0, 16'h0, 1'b1);
      if (!usb_pktend_n) found = 1'b1;
    end
    check("pe_wait", 64'(found), 64'd1);
    din_en = 1'b1;
    din = 16'h5a5a;
    drive(1'b0, 16'h0, 1'b1);
    check("pe_after", 64'({usb_pktend_n, usb_slwr_n}), 64'd3);
    drive(1'b0, 16'h0, 1'b1);
    check("pe_push_out", 64'({usb_slwr_n, usb_fd}), 64'({1'b0, 16'h5a5a}));

    // Synchronous clear with words buffered behind a stall.
    do_clear();
    for (int i = 0; i < 3; i++) drive(1'b1, 16'(16'h0800 + i), 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b0, 16'h0, 1'b1);
    check("clr_pre_ws", 64'(words_sent), 64'd3);
    for (int i = 0; i < 5; i++) drive(1'b1, 16'(16'h0900 + i), 1'b0);
    do_clear();
    for (int i = 0; i < 10; i++) drive(1'b0, 16'h0, 1'b1);
    check("clr_nostrobe", 64'(got_q.size()), 64'd0);
    check("clr_ovf_ws", 64'({overflow, words_sent}), 64'd0);

    // Asynchronous reset while a strobe is on the bus.
    for (int i = 0; i < 3; i++) drive(1'b1, 16'(16'h0a00 + i), 1'b1);
    check("arst_pre", 64'(usb_slwr_n), 64'd0);
    #2;
    reset_n = 1'b0;
    din_en = 1'b0;
    #1;
    check("arst_now", 64'({usb_slwr_n, usb_pktend_n, usb_fd, words_sent}), 64'({2'b11, 32'h0}));
    @(negedge clk);
    reset_n = 1'b1;

    // Randomized traffic with bursty stalls, gaps and rare clears.
    stall_left = 0;
    gap_left = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst_all_fifo = ($urandom_range(0, 599) == 0);
      if (gap_left > 0) begin
        gap_left--;
        din_en = 1'b0;
      end else begin
        if ($urandom_range(0, 99) == 0) gap_left = $urandom_range(1, 40);
        din_en = ($urandom_range(0, 3) != 0);
      end
      din = 16'($urandom);
      if (stall_left > 0) begin
        stall_left--;
        usb_pfull_n = 1'b0;
      end else begin
        if ($urandom_range(0, 19) == 0) stall_left = $urandom_range(1, 25);
        usb_pfull_n = 1'b1;
      end
    end
    rst_all_fifo = 1'b0;
    for (int i = 0; i < 1100; i++) drive(1'b0, 16'h0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
